// File: rtl/pix_line_packer.sv
// Packs CCD line pixels into a 16x16 FIFO behind a per-line header word and streams them out as MSB-first bytes.
// Optional build macro PIX_DARK_SUB_EN: subtract black_level from each pixel, clamping at zero.
module pix_line_packer (
    input  logic        clk_160M,
    input  logic        nrst,
    input  logic        en,
    input  logic        pix_clk,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic [15:0] black_level,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        line_done,
    output logic [11:0] pix_count,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, WAIT_LINE, HEADER, PIXELS} state_t;

    state_t      state, state_nxt;
    logic [2:0]  pclk_sync, pval_sync;
    logic [1:0]  sync_warm;
    logic        armed;
    logic        pclk_rise, pval_rise, pval_fall, capture;
    logic [15:0] pix_value;
    logic [15:0] cap_word;
    logic        cap_pending;
    logic [7:0]  line_cnt;
    logic [11:0] line_pix;
    logic        push;
    logic [15:0] push_word;
    logic [15:0] mem [16];
    logic [3:0]  wr_ptr, rd_ptr;
    logic [4:0]  fill;
    logic        fifo_empty, fifo_full, pop_req, do_pop, do_push;
    logic [7:0]  lo_byte;
    logic        have_lo;

    // Bits [1:0] are the synchronisers proper; bit [2] is edge-detect history.
    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            pclk_sync <= '0;
            pval_sync <= '0;
            sync_warm <= '0;
            armed     <= 1'b0;
        end else begin
            pclk_sync <= {pclk_sync[1:0], pix_clk};
            pval_sync <= {pval_sync[1:0], pix_valid};
            sync_warm <= {sync_warm[0], 1'b1};
            armed     <= armed | (sync_warm[1] & ~pval_sync[1]);
        end
    end

    // A line may only start after pix_valid has been seen low since reset, so a
    // window already open at reset release never yields a header.
    assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
    assign pval_rise = pval_sync[1] & ~pval_sync[2];
    assign pval_fall = ~pval_sync[1] & pval_sync[2];
    assign capture   = pclk_rise & pval_sync[1];

`ifdef PIX_DARK_SUB_EN
    always_comb begin
        pix_value = (black_level > pix_data) ? 16'h0000 : (pix_data - black_level);
    end
`else
    logic unused_black_level;
    assign unused_black_level = ^black_level;
    always_comb begin
        pix_value = pix_data;
    end
`endif

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            cap_word    <= '0;
            cap_pending <= 1'b0;
        end else begin
            cap_pending <= capture & ((state == HEADER) | (state == PIXELS));
            if (capture) cap_word <= pix_value;
        end
    end

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (en) state_nxt = WAIT_LINE;
            WAIT_LINE: begin
                if (!en)                    state_nxt = IDLE;
                else if (pval_rise && armed) state_nxt = HEADER;
            end
            HEADER:    state_nxt = PIXELS;
            PIXELS:    if (pval_fall) state_nxt = en ? WAIT_LINE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            line_pix  <= '0;
            pix_count <= '0;
            line_cnt  <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (state == HEADER) begin
                line_pix <= {11'd0, capture};
            end else if (state == PIXELS && capture && line_pix != 12'hFFF) begin
                line_pix <= line_pix + 12'd1;
            end
            if (state == PIXELS && pval_fall) begin
                line_done <= 1'b1;
                pix_count <= line_pix;
                line_cnt  <= line_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        push      = (state == HEADER) | cap_pending;
        push_word = (state == HEADER) ? {8'hA5, line_cnt} : cap_word;
    end

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push when drained.
    assign fifo_empty = (fill == 5'd0);
    assign fifo_full  = (fill == 5'd16);
    assign pop_req    = (~out_valid | out_ready) & ~have_lo;
    assign do_pop     = pop_req & ~fifo_empty;
    assign do_push    = push & (~fifo_full | do_pop);

    always_ff @(posedge clk_160M) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 4'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
            fill <= fill + {4'd0, do_push} - {4'd0, do_pop};
            if (push && !do_push)              overflow <= 1'b1;
            else if (state == IDLE && en)      overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_160M or negedge nrst) begin
        if (!nrst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            lo_byte   <= '0;
            have_lo   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (have_lo) begin
                out_data  <= lo_byte;
                out_valid <= 1'b1;
                have_lo   <= 1'b0;
            end else if (!fifo_empty) begin
                out_data  <= mem[rd_ptr][15:8];
                lo_byte   <= mem[rd_ptr][7:0];
                have_lo   <= 1'b1;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pix_line_packer.sv
// Self-checking bench for pix_line_packer: directed and random lines compared against a byte-stream model.
module tb_pix_line_packer;

    logic        clk_160M = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        pix_clk = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic [15:0] black_level = 16'h0;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        line_done;
    logic [11:0] pix_count;
    logic        overflow;

    int checks = 0;
    int passed = 0;
    int lineNo = 0;
    int donePulses = 0;
    int stallBad = 0;
    int readyMode = 1;
    logic [7:0]  rxQ[$];
    logic [7:0]  expQ[$];
    logic [15:0] linePix[$];
    logic        prevStall = 1'b0;
    logic [7:0]  prevData = 8'h0;

    pix_line_packer dut (
        .clk_160M(clk_160M), .nrst(nrst), .en(en), .pix_clk(pix_clk),
        .pix_valid(pix_valid), .pix_data(pix_data), .black_level(black_level),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .line_done(line_done), .pix_count(pix_count), .overflow(overflow)
    );

    always #3 clk_160M = ~clk_160M;

    always @(posedge clk_160M) begin
        #1;
        if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
        else                out_ready = (readyMode == 1);
    end

    always @(negedge clk_160M) begin
        if (!nrst) begin
            prevStall = 1'b0;
        end else begin
            if (out_valid && out_ready) rxQ.push_back(out_data);
            if (prevStall && !(out_valid === 1'b1 && out_data === prevData)) stallBad++;
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            if (line_done) donePulses++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_160M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] xform(input logic [15:0] p, input logic [15:0] b);
`ifdef PIX_DARK_SUB_EN
        return (b > p) ? 16'h0000 : 16'(p - b);
`else
        return p;
`endif
    endfunction

    task automatic pushWord(input logic [15:0] w);
        expQ.push_back(w[15:8]);
        expQ.push_back(w[7:0]);
    endtask

    // Expected stream of one accepted line: header, then at most maxPix pixels.
    task automatic modelLine(input int maxPix);
        logic [7:0] ln;
        ln = 8'(lineNo);
        pushWord({8'hA5, ln});
        for (int i = 0; i < linePix.size() && i < maxPix; i++)
            pushWord(xform(linePix[i], black_level));
        lineNo = (lineNo + 1) & 255;
    endtask

    task automatic pulsePixel(input logic [15:0] v);
        pix_data = v;
        tick(5);
        pix_clk = 1'b1;
        tick(5);
        pix_clk = 1'b0;
    endtask

    task automatic applyStimulus(input int dropAfter);
        pix_valid = 1'b1;
        tick(8);
        for (int i = 0; i < linePix.size(); i++) begin
            pulsePixel(linePix[i]);
            if (i + 1 == dropAfter) en = 1'b0;
        end
        tick(5);
        pix_valid = 1'b0;
        tick(8);
    endtask

    task automatic checkOutput(input string tag);
        int n;
        for (int i = 0; i < 3000 && rxQ.size() < expQ.size(); i++) tick(1);
        tick(6);
        check({tag, " bytecount"}, rxQ.size(), expQ.size());
        n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte%0d", tag, i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
        rxQ.delete();
        expQ.delete();
    endtask

    initial begin
        int d0;
        // Reset values
        tick(3);
        check("rst out_valid", {31'd0, out_valid}, 0);
        check("rst out_data", {24'd0, out_data}, 0);
        check("rst line_done", {31'd0, line_done}, 0);
        check("rst pix_count", {20'd0, pix_count}, 0);
        check("rst overflow", {31'd0, overflow}, 0);
        nrst = 1'b1;
        tick(4);

        // Basic four-pixel line
        en = 1'b1;
        readyMode = 1;
        tick(4);
        linePix = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000};
        modelLine(1000);
        d0 = donePulses;
        applyStimulus(-1);
        checkOutput("basic");
        check("basic done", donePulses - d0, 1);
        check("basic pix_count", {20'd0, pix_count}, 4);
        check("basic overflow", {31'd0, overflow}, 0);

        // Random lines, random data and dark level, random backpressure
        readyMode = 2;
        for (int l = 0; l < 4; l++) begin
            int n;
            n = $urandom_range(1, 10);
            black_level = 16'($urandom);
            linePix.delete();
            for (int i = 0; i < n; i++) linePix.push_back(16'($urandom));
            modelLine(1000);
            applyStimulus(-1);
            checkOutput($sformatf("rand%0d", l));
            check($sformatf("rand%0d pix_count", l), {20'd0, pix_count}, n);
        end
        black_level = 16'h0;

        // Stalled output through a 20-pixel line: header sits in the output stage, 16 words fill the FIFO
        readyMode = 0;
        tick(2);
        linePix.delete();
        for (int i = 0; i < 20; i++) linePix.push_back(16'($urandom));
        modelLine(16);
        stallBad = 0;
        applyStimulus(-1);
        check("stall overflow", {31'd0, overflow}, 1);
        check("stall out_valid", {31'd0, out_valid}, 1);
        check("stall head byte", {24'd0, out_data}, 32'hA5);
        check("stall nobytes", rxQ.size(), 0);
        check("stall pix_count", {20'd0, pix_count}, 20);
        readyMode = 1;
        checkOutput("stall");
        check("stall stable", stallBad, 0);
        check("overflow sticky", {31'd0, overflow}, 1);
        en = 1'b0;
        tick(4);
        check("overflow kept idle", {31'd0, overflow}, 1);
        en = 1'b1;
        tick(4);
        check("overflow cleared", {31'd0, overflow}, 0);

        // Dark subtraction case
        black_level = 16'h0100;
        linePix = '{16'h0180, 16'h0050};
        modelLine(1000);
        applyStimulus(-1);
        checkOutput("dark");
        black_level = 16'h0;

        // en dropped mid-line: the line completes, no further lines start
        linePix = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E};
        modelLine(1000);
        d0 = donePulses;
        applyStimulus(2);
        checkOutput("endrop");
        check("endrop pix_count", {20'd0, pix_count}, 5);
        check("endrop done", donePulses - d0, 1);
        linePix = '{16'h5555, 16'h6666};
        applyStimulus(-1);
        tick(10);
        check("endrop noheader", rxQ.size(), 0);
        check("endrop nodone", donePulses - d0, 1);
        en = 1'b1;
        tick(4);

        // 256+1 short lines from a clean reset to exercise the header counter wrap
        nrst = 1'b0;
        tick(2);
        check("rst2 pix_count", {20'd0, pix_count}, 0);
        nrst = 1'b1;
        lineNo = 0;
        rxQ.delete();
        tick(4);
        for (int l = 0; l < 257; l++) begin
            linePix.delete();
            linePix.push_back(16'($urandom));
            modelLine(1000);
            applyStimulus(-1);
            checkOutput($sformatf("wrap%0d", l));
        end

        // Reset mid-line discards the rest; header restarts at 0xA500 on the next line
        pix_valid = 1'b1;
        tick(8);
        pulsePixel(16'h1111);
        pulsePixel(16'h2222);
        nrst = 1'b0;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 0);
        tick(2);
        rxQ.delete();
        expQ.delete();
        nrst = 1'b1;
        pulsePixel(16'h3333);
        pulsePixel(16'h4444);
        tick(5);
        pix_valid = 1'b0;
        tick(20);
        check("midrst nobytes", rxQ.size(), 0);
        check("midrst out_valid2", {31'd0, out_valid}, 0);
        lineNo = 0;
        linePix = '{16'hBEEF, 16'h0102};
        modelLine(1000);
        applyStimulus(-1);
        checkOutput("afterrst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pix_line_packer.md
PIX_LINE_PACKER -- requirements
Module: pix_line_packer

Interface
REQ-001 SHALL have port clk_160M  input  1  system clock; all logic is on its rising edge; one clock only.
REQ-002 SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port en  input  1  capture enable, sampled in clk_160M.
REQ-004 SHALL have port pix_clk  input  1  pixel strobe from the CCD timing stage, asynchronous to clk_160M; pix_data is stable from its falling edge.
REQ-005 SHALL have port pix_valid  input  1  line-valid window from the CCD timing stage, asynchronous.
REQ-006 SHALL have port pix_data  input  16  ADC sample, quasi-static between pix_clk falling edges.
REQ-007 SHALL have port black_level  input  16  dark offset, static during a line.
REQ-008 SHALL have port out_data  output  8  byte stream to the host interface.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  host accepts the byte in a cycle where out_valid=1 and out_ready=1.
REQ-011 SHALL have port line_done  output  1  one-cycle pulse at end of line.
REQ-012 SHALL have port pix_count  output  12  pixels captured in the last completed line.
REQ-013 SHALL have port overflow  output  1  sticky flag: a word was dropped.

Function
REQ-014 SHALL pass pix_clk and pix_valid through two-flop synchronisers each; downstream logic SHALL use only the synchronised copies.
REQ-015 SHALL detect a rising edge of synced pix_clk while synced pix_valid=1 as a capture event, and SHALL register pix_data on that cycle.
REQ-016 SHALL implement states IDLE, WAIT_LINE, HEADER, PIXELS.
REQ-017 SHALL move IDLE->WAIT_LINE when en=1.
REQ-018 SHALL move WAIT_LINE->HEADER on a synced pix_valid 0->1 transition.
REQ-019 SHALL, in HEADER, push the single word 0xA500|line_cnt[7:0] into the FIFO, then move to PIXELS.
REQ-020 SHALL, in PIXELS, push every captured pixel exactly 1 cycle after its capture event.
REQ-021 SHALL, on a synced pix_valid 1->0 transition in PIXELS: pulse line_done, load pix_count, increment the 8-bit line_cnt (wraps 255->0), and go to WAIT_LINE if en=1, else IDLE.
REQ-022 SHALL let a line in progress finish when en falls mid-line; a line SHALL never start while en=0.
REQ-023 SHALL use a FIFO of 16 words x 16 bits; with both push and pop requested: if full, SHALL pop and accept the push; if empty, SHALL accept the push and not pop.
REQ-024 SHALL, on a push to a full FIFO without a simultaneous pop, drop the word and set overflow.
REQ-025 SHALL clear overflow only on reset or on the IDLE->WAIT_LINE transition.
REQ-026 SHALL serialise each FIFO word as two bytes, MSB first.
REQ-027 SHALL assert out_valid no later than 2 cycles after the FIFO becomes non-empty.
REQ-028 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL saturate pix_count at 4095, and line_cnt SHALL not change on an aborted line (reset).

Reset
REQ-030 SHALL, while nrst=0, force: state IDLE, FIFO empty, synchronisers 0, out_data 0, out_valid 0, line_done 0, pix_count 0, line_cnt 0, overflow 0.
REQ-031 SHALL, on reset mid-line, discard the partial line, and SHALL need a fresh pix_valid rising edge after release before emitting a header.

Configuration
REQ-032 SHALL, when macro PIX_DARK_SUB_EN is defined, push the value pix_data-black_level, clamped to 0 when black_level>pix_data.
REQ-033 SHALL, when PIX_DARK_SUB_EN is undefined, push raw pix_data and ignore black_level; header words are never modified in either build.

Verification
REQ-034 SHALL cover: en=1, line of 4 pixels 0x1234,0x0001,0xFFFF,0x8000 with out_ready=1 -> bytes A5 00 12 34 00 01 FF FF 80 00, line_done pulse, pix_count=4.
REQ-035 SHALL cover: out_ready=0 through a 20-pixel line -> 16 words retained, overflow=1, first bytes A5 00, out_data stable while stalled.
REQ-036 SHALL cover: PIX_DARK_SUB_EN defined, black_level=0x0100, pixels 0x0180,0x0050 -> pixel words 0x0080,0x0000; undefined -> 0x0180,0x0050.
REQ-037 SHALL cover: en dropped after pixel 2 of 5 -> all 5 pixels emitted, state IDLE, next pix_valid pulse produces no header.
REQ-038 SHALL cover: 256 short lines -> 256th header 0xA5FF and 257th header 0xA500; nrst pulse mid-line -> out_valid=0 and no bytes until the next line's header 0xA500.
